matrix_stream_detile: RTL and testbench



---
 rtl/matrix_stream_detile.sv | 165 ++++++++++++++++
 tb/tb_matrix_stream_detile.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_stream_detile.sv
// Output-side reorder stage: accepts tile-row-major matrix tiles and re-emits
// the matrix in raster order, one COMPUTE_DIM0-wide row segment per beat.
module matrix_stream_detile #(
    parameter int DATA_WIDTH   = 16,
    parameter int TOTAL_DIM0   = 4,
    parameter int TOTAL_DIM1   = 4,
    parameter int COMPUTE_DIM0 = 2,
    parameter int COMPUTE_DIM1 = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data [COMPUTE_DIM0*COMPUTE_DIM1],
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data [COMPUTE_DIM0],
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    localparam int DEPTH_DIM0 = TOTAL_DIM0 / COMPUTE_DIM0;
    localparam int DEPTH_DIM1 = TOTAL_DIM1 / COMPUTE_DIM1;
    localparam int TILE_N     = COMPUTE_DIM0 * COMPUTE_DIM1;
    localparam int BLK_W      = (DEPTH_DIM0   > 1) ? $clog2(DEPTH_DIM0)   : 1;
    localparam int ROW_W      = (COMPUTE_DIM1 > 1) ? $clog2(COMPUTE_DIM1) : 1;
    localparam int BROW_W     = (DEPTH_DIM1   > 1) ? $clog2(DEPTH_DIM1)   : 1;

    if (TOTAL_DIM0 % COMPUTE_DIM0 != 0) begin : g_bad_dim0
        $fatal(1, "matrix_stream_detile: COMPUTE_DIM0 must divide TOTAL_DIM0");
    end
    if (TOTAL_DIM1 % COMPUTE_DIM1 != 0) begin : g_bad_dim1
        $fatal(1, "matrix_stream_detile: COMPUTE_DIM1 must divide TOTAL_DIM1");
    end

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } bank_state_e;

    bank_state_e             status_q [2];
    bank_state_e             status_d [2];
    logic                    active_q;
    logic                    wr_bank_q, wr_bank_d;
    logic [BLK_W-1:0]        wr_blk_q,  wr_blk_d;
    logic                    rd_bank_q, rd_bank_d;
    logic [BLK_W-1:0]        rd_blk_q,  rd_blk_d;
    logic [ROW_W-1:0]        rd_row_q,  rd_row_d;
    logic [BROW_W-1:0]       rd_brow_q, rd_brow_d;

    // Tile storage: bank, tile slot within the block-row, element.
    logic [DATA_WIDTH-1:0]   mem_q [2][DEPTH_DIM0][TILE_N];
    logic [DATA_WIDTH-1:0]   rd_tile [TILE_N];

    logic wr_fire, rd_fire;
    logic wr_blk_last, rd_blk_last, rd_row_last, rd_brow_last;

    // active_q keeps in_ready low while rst_n is held, from a register only.
    assign in_ready  = active_q && (status_q[wr_bank_q] == EMPTY);
    assign out_valid = active_q && (status_q[rd_bank_q] == FULL);
    assign wr_fire   = in_valid && in_ready;
    assign rd_fire   = out_valid && out_ready;

    assign wr_blk_last  = (wr_blk_q  == BLK_W'(DEPTH_DIM0 - 1));
    assign rd_blk_last  = (rd_blk_q  == BLK_W'(DEPTH_DIM0 - 1));
    assign rd_row_last  = (rd_row_q  == ROW_W'(COMPUTE_DIM1 - 1));
    assign rd_brow_last = (rd_brow_q == BROW_W'(DEPTH_DIM1 - 1));

    assign out_last = out_valid && rd_brow_last && rd_row_last && rd_blk_last;

    always_comb begin
        for (int e = 0; e < TILE_N; e++) begin
            rd_tile[e] = mem_q[rd_bank_q][0][e];
        end
        for (int b = 1; b < DEPTH_DIM0; b++) begin
            if (rd_blk_q == BLK_W'(b)) begin
                rd_tile = mem_q[rd_bank_q][b];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < COMPUTE_DIM0; c++) begin
            out_data[c] = rd_tile[c];
        end
        for (int r = 1; r < COMPUTE_DIM1; r++) begin
            if (rd_row_q == ROW_W'(r)) begin
                for (int c = 0; c < COMPUTE_DIM0; c++) begin
                    out_data[c] = rd_tile[r*COMPUTE_DIM0 + c];
                end
            end
        end
    end

    always_comb begin
        status_d  = status_q;
        wr_bank_d = wr_bank_q;
        wr_blk_d  = wr_blk_q;
        rd_bank_d = rd_bank_q;
        rd_blk_d  = rd_blk_q;
        rd_row_d  = rd_row_q;
        rd_brow_d = rd_brow_q;

        if (wr_fire) begin
            if (wr_blk_last) begin
                status_d[wr_bank_q] = FULL;
                wr_bank_d           = ~wr_bank_q;
                wr_blk_d            = '0;
            end else begin
                wr_blk_d = wr_blk_q + BLK_W'(1);
            end
        end

        // Read and write always address different banks, so both status
        // updates can land in the same cycle.
        if (rd_fire) begin
            if (rd_blk_last) begin
                rd_blk_d = '0;
                if (rd_row_last) begin
                    rd_row_d            = '0;
                    status_d[rd_bank_q] = EMPTY;
                    rd_bank_d           = ~rd_bank_q;
                    rd_brow_d           = rd_brow_last ? '0 : rd_brow_q + BROW_W'(1);
                end else begin
                    rd_row_d = rd_row_q + ROW_W'(1);
                end
            end else begin
                rd_blk_d = rd_blk_q + BLK_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            status_q[0] <= EMPTY;
            status_q[1] <= EMPTY;
            active_q    <= 1'b0;
            wr_bank_q   <= 1'b0;
            wr_blk_q    <= '0;
            rd_bank_q   <= 1'b0;
            rd_blk_q    <= '0;
            rd_row_q    <= '0;
            rd_brow_q   <= '0;
        end else begin
            status_q    <= status_d;
            active_q    <= 1'b1;
            wr_bank_q   <= wr_bank_d;
            wr_blk_q    <= wr_blk_d;
            rd_bank_q   <= rd_bank_d;
            rd_blk_q    <= rd_blk_d;
            rd_row_q    <= rd_row_d;
            rd_brow_q   <= rd_brow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int b = 0; b < DEPTH_DIM0; b++) begin
                if (wr_blk_q == BLK_W'(b)) begin
                    mem_q[wr_bank_q][b] <= in_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_matrix_stream_detile.sv
// Scoreboard bench for matrix_stream_detile: default 4x4/2x2 instance plus a
// 4x4/4x1 instance for the single-row-tile shape.
module tb_matrix_stream_detile;

    localparam int DW  = 16;
    localparam int TD0 = 4;
    localparam int TD1 = 4;
    localparam int CD0 = 2;
    localparam int CD1 = 2;
    localparam int D0  = TD0 / CD0;

    logic clk = 1'b0;
    logic rst_n;
    logic [DW-1:0] in_data [CD0*CD1];
    logic in_valid, in_ready;
    logic [DW-1:0] out_data [CD0];
    logic out_valid, out_ready, out_last;

    logic [DW-1:0] dg_in_data [4];
    logic dg_in_valid, dg_in_ready;
    logic [DW-1:0] dg_out_data [4];
    logic dg_out_valid, dg_out_ready, dg_out_last;

    typedef struct {
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic          last;
    } seg_t;

    seg_t sb [$];
    int   errors = 0;
    int   checks = 0;
    bit   rand_rdy = 0;

    logic          stalled = 0;
    logic [DW-1:0] p0, p1;
    logic          plast;

    always #5 clk = ~clk;

    matrix_stream_detile #(
        .DATA_WIDTH(DW), .TOTAL_DIM0(TD0), .TOTAL_DIM1(TD1),
        .COMPUTE_DIM0(CD0), .COMPUTE_DIM1(CD1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last)
    );

    matrix_stream_detile #(
        .DATA_WIDTH(DW), .TOTAL_DIM0(4), .TOTAL_DIM1(4),
        .COMPUTE_DIM0(4), .COMPUTE_DIM1(1)
    ) dut_dg (
        .clk(clk), .rst_n(rst_n),
        .in_data(dg_in_data), .in_valid(dg_in_valid), .in_ready(dg_in_ready),
        .out_data(dg_out_data), .out_valid(dg_out_valid), .out_ready(dg_out_ready),
        .out_last(dg_out_last)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    // Raster-order segments of a matrix whose element (r,c) is base+4r+c.
    task automatic push_expected(input int base);
        seg_t s;
        for (int r = 0; r < TD1; r++) begin
            for (int b = 0; b < D0; b++) begin
                s.d0   = DW'(base + r*TD0 + b*CD0);
                s.d1   = DW'(base + r*TD0 + b*CD0 + 1);
                s.last = (r == TD1-1) && (b == D0-1);
                sb.push_back(s);
            end
        end
    endtask

    // Drive tile t (tile-row-major) and hold it until accepted.
    task automatic send_tile(input int base, input int t, input bit rand_idle, output logic ov_at_accept);
        int n;
        int brow, blk;
        brow = t / D0;
        blk  = t % D0;
        if (rand_idle) begin
            in_valid = 1'b0;
            while ($urandom_range(0, 1) == 1) step();
        end
        for (int r = 0; r < CD1; r++)
            for (int c = 0; c < CD0; c++)
                in_data[r*CD0+c] = DW'(base + (brow*CD1 + r)*TD0 + blk*CD0 + c);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) chk("in_ready_timeout", 64'(in_ready), 64'd1);
        ov_at_accept = out_valid;
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_matrix(input int base, input bit rand_idle);
        logic ov;
        push_expected(base);
        for (int t = 0; t < D0*(TD1/CD1); t++) send_tile(base, t, rand_idle, ov);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        rand_rdy  = 0;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            step();
            n++;
        end
        step();
        chk({tag, "_sb_left"}, 64'(sb.size()), 64'd0);
        chk({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
    endtask

    always @(negedge clk) begin
        seg_t e;
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_d0", 64'(out_data[0]), 64'(p0));
                chk("stall_d1", 64'(out_data[1]), 64'(p1));
                chk("stall_last", 64'(out_last), 64'(plast));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("extra_beat", 64'(out_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("seg_d0", 64'(out_data[0]), 64'(e.d0));
                    chk("seg_d1", 64'(out_data[1]), 64'(e.d1));
                    chk("seg_last", 64'(out_last), 64'(e.last));
                end
            end
            stalled = out_valid && !out_ready;
            p0      = out_data[0];
            p1      = out_data[1];
            plast   = out_last;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ov;
        int   n;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        dg_in_valid  = 1'b0;
        dg_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data[i]    = '0;
            dg_in_data[i] = '0;
        end
        step();
        step();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);

        // Basic order and first-output latency.
        push_expected(0);
        send_tile(0, 0, 0, ov);
        chk("lat_valid_after_t0", 64'(out_valid), 64'd0);
        send_tile(0, 1, 0, ov);
        chk("lat_valid_after_t1", 64'(out_valid), 64'd1);
        send_tile(0, 2, 0, ov);
        send_tile(0, 3, 0, ov);
        wait_drain("basic");

        // Backpressure: four tiles fill both banks, the fifth is refused.
        out_ready = 1'b0;
        send_matrix(0, 0);
        push_expected(64);
        for (int r = 0; r < CD1; r++)
            for (int c = 0; c < CD0; c++)
                in_data[r*CD0+c] = DW'(64 + r*TD0 + c);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_hold_d0", 64'(out_data[0]), 64'd0);
            chk("bp_hold_d1", 64'(out_data[1]), 64'd1);
            step();
        end
        out_ready = 1'b1;
        for (int t = 0; t < 4; t++) send_tile(64, t, 0, ov);
        wait_drain("bp");

        // Ping-pong: three back-to-back matrices.
        for (int m = 0; m < 3; m++) begin
            push_expected(16*m + 128);
            for (int t = 0; t < 4; t++) begin
                send_tile(16*m + 128, t, 0, ov);
                if (m == 0 && t == 2) chk("pp_overlap_valid", 64'(ov), 64'd1);
            end
        end
        wait_drain("pp");

        // Random stalls on both sides.
        rand_rdy = 1;
        for (int m = 0; m < 100; m++) send_matrix(16*m + 300, 1);
        wait_drain("rand");

        // Reset mid-stream after 3 tiles and 2 output beats.
        out_ready = 1'b0;
        push_expected(2000);
        for (int t = 0; t < 3; t++) send_tile(2000, t, 0, ov);
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        rst_n = 1'b0;
        step();
        sb.delete();
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_out_last", 64'(out_last), 64'd0);
        rst_n = 1'b1;
        step();
        chk("mid_rst_rel_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_rel_out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        send_matrix(0, 0);
        wait_drain("after_rst");

        // Single-row tiles: each tile comes back unchanged.
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 4; c++) dg_in_data[c] = DW'(1000 + 4*k + c);
            dg_in_valid = 1'b1;
            n = 0;
            while (!dg_in_ready && n < 50) begin
                step();
                n++;
            end
            if (n >= 50) chk("dg_in_ready_timeout", 64'(dg_in_ready), 64'd1);
            step();
            dg_in_valid = 1'b0;
            chk("dg_valid", 64'(dg_out_valid), 64'd1);
            for (int c = 0; c < 4; c++) chk("dg_data", 64'(dg_out_data[c]), 64'(1000 + 4*k + c));
            chk("dg_last", 64'(dg_out_last), 64'(k == 3));
        end
        step();
        chk("dg_idle_valid", 64'(dg_out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
